sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the next generation of the team's sync FIFO. It adds:
- non-power-of-two depth
- occupancy count
- programmable almost-full/almost-empty flags
- sticky overflow/underflow error flags
- synchronous flush
- selectable registered-output or first-word-fall-through (FWFT) read mode

It is the default buffering element between single-clock datapath stages.

Parameters:
- DATA_WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries (>=2, any integer).
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0, read mode: 0 = registered output (1-cycle latency); 1 = first-word-fall-through.
- CNT_WIDTH, $clog2(DEPTH+1), width of count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO contents.
- clr_err  input  1  synchronous clear of overflow/underflow.
- wr_en  input  1  write request.
- din  input  DATA_WIDTH  write data.
- rd_en  input  1  read (pop) request.
- dout  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  CNT_WIDTH  current occupancy.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd/wr pointers = 0, count = 0, dout = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Reset release is synchronous to clk by the integrating block; the FIFO accepts wr_en on the first edge after rst_n is high.
- Acceptance uses flags as they stand before the edge:
  - wr_ok = wr_en & !full
  - rd_ok = rd_en & !empty
- Write: on wr_ok, mem[wr_ptr] <= din; wr_ptr advances; at DEPTH-1 it wraps to 0.
- Read: on rd_ok, rd_ptr advances with the same wrap rule.
- count:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
  - All flags are registered and derived from next-state count, so they are valid in the cycle after the causing edge.
- Simultaneous rd_en/wr_en:
  - When full: read accepted, write rejected, overflow set, count drops to DEPTH-1.
  - When empty: write accepted, read rejected, underflow set, count becomes 1. No bypass: in FWFT mode the data appears after the edge.
  - Otherwise both are accepted and count is held.
- FWFT=0: dout <= mem[rd_ptr] on rd_ok; dout holds its value otherwise, including while empty.
- FWFT=1:
  - dout continuously presents the head entry mem[rd_ptr] (combinational read of registered pointer).
  - rd_en acts as pop/acknowledge.
  - dout is don't-care while empty.
- overflow/underflow:
  - Set on the edge of the offending request; the offending access changes no state.
  - Held until clr_err or reset.
  - If set and clr_err occur in the same cycle, set wins.
- flush:
  - Pointers and count go to 0; empty = 1 and flags update accordingly.
  - Same-cycle wr_en/rd_en are ignored.
  - Does not clear error flags or dout.
- The full count encoding (DEPTH entries) is distinguished from empty by count, not by pointer equality.

Test Plan:
- Basic order (DATA_WIDTH=8, DEPTH=16, FWFT=0): reset, write 0x01..0x10 on 16 consecutive edges -> full=1, count=16, almost_full=1 from count 14. Then read 16 -> dout = 0x01..0x10 each one cycle after rd_en; empty=1, no error flags.
- Overflow/underflow: with full, hold wr_en with din=0xAA -> overflow=1 and contents unchanged. Read all, then one extra rd_en -> underflow=1 and dout holds 0x10. Pulse clr_err -> both flags 0.
- Simultaneous access:
  - At count=5, rd_en & wr_en for 4 cycles -> count stays 5 and order is preserved.
  - At empty, both asserted -> count=1, underflow=1.
  - At full, both asserted -> count=15, overflow=1.
- Wrap and odd depth (DEPTH=5): 3 write / 3 read rounds for 20 words (0x00..0x13) -> all data returned in order across pointer wrap; full only at count=5.
- FWFT=1: write 0x3C into empty FIFO -> dout=0x3C the cycle after the write with no rd_en. Write 0x3D, pulse rd_en -> dout=0x3D next cycle, count=1.
- Flush and async reset: at count=9, flush with wr_en=1 -> count=0, empty=1, written word discarded. Refill to 7, drop rst_n mid-cycle -> all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock FIFO. DEPTH may be any integer of 2 or more. The block reports
// its occupancy, has programmable almost-full and almost-empty thresholds, and
// has sticky overflow and underflow flags. It supports a synchronous flush. The
// read port works in one of two modes:
//   FWFT=0 : registered output. dout updates one cycle after an accepted read.
//   FWFT=1 : first-word-fall-through. dout always shows the head entry, and
//            rd_en acts as the pop/acknowledge.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of contents (pointers/count to 0)
//   clr_err      synchronous clear of overflow/underflow
//   wr_en, din   write request and data
//   rd_en        read (pop) request
//   dout         read data
//   full, empty, almost_full, almost_empty  registered status flags
//   count        current occupancy, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
//
// Handshake: a write is taken on an edge where wr_en is high and full is low.
// A read is taken on an edge where rd_en is high and empty is low. Both
// decisions use the flags as they stand before the edge. A request that is
// refused changes no state; it only raises the matching sticky error flag.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 af_q, af_d;
    logic                 ae_q, ae_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 wr_ok, rd_ok;

    // The depth need not be a power of two, so the pointers wrap explicitly.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_comb begin
        // A flush overrides any request made in the same cycle.
        wr_ok    = wr_en & ~full_q & ~flush;
        rd_ok    = rd_en & ~empty_q & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_ok && !rd_ok)      count_d = count_q + CNT_WIDTH'(1);
            else if (rd_ok && !wr_ok) count_d = count_q - CNT_WIDTH'(1);
        end

        // A new error event wins over clr_err in the same cycle.
        ovf_d = (ovf_q & ~clr_err) | (wr_en & full_q & ~flush);
        udf_d = (udf_q & ~clr_err) | (rd_en & empty_q & ~flush);

        // The flags are computed from the next count, so they line up with
        // count in the cycle after the edge that caused the change.
        // Full and empty are told apart by count, not by pointer equality.
        full_d  = (count_d == CNT_WIDTH'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_WIDTH'(AF_LEVEL));
        ae_d    = (count_d <= CNT_WIDTH'(AE_LEVEL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // The storage array is not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

    generate
        if (FWFT == 0) begin : g_reg_out
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            // dout keeps its value unless a read is accepted. It is not
            // cleared by flush.
            always_comb begin
                dout_d = dout_q;
                if (rd_ok) dout_d = mem_q[rd_ptr_q];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else        dout_q <= dout_d;
            end

            assign dout = dout_q;
        end else begin : g_fwft_out
            // The head entry is visible directly. Its value means nothing
            // while the FIFO is empty.
            assign dout = mem_q[rd_ptr_q];
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic clk;
  logic rst_n;

  // Instance a: DEPTH=16, registered output
  logic       flush_a, clr_a, wr_a, rd_a;
  logic [7:0] din_a, dout_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [4:0] count_a;

  // Instance b: DEPTH=5 (odd), registered output
  logic       flush_b, clr_b, wr_b, rd_b;
  logic [7:0] din_b, dout_b;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [2:0] count_b;

  // Instance c: DEPTH=16, FWFT
  logic       flush_c, clr_c, wr_c, rd_c;
  logic [7:0] din_c, dout_c;
  logic       full_c, empty_c, af_c, ae_c, ovf_c, udf_c;
  logic [4:0] count_c;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic       rd_issue_a = 0, rd_issue_b = 0;
  logic       rd_pend_a = 0, rd_pend_b = 0;
  logic [7:0] mon_exp;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .clr_err(clr_a), .wr_en(wr_a), .din(din_a),
    .rd_en(rd_a), .dout(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a));

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .clr_err(clr_b), .wr_en(wr_b), .din(din_b),
    .rd_en(rd_b), .dout(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b));

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .clr_err(clr_c), .wr_en(wr_c), .din(din_c),
    .rd_en(rd_c), .dout(dout_c), .full(full_c), .empty(empty_c), .almost_full(af_c),
    .almost_empty(ae_c), .count(count_c), .overflow(ovf_c), .underflow(udf_c));

  // ---------------- clock ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cyc_a(input logic wr, input logic [7:0] d, input logic rd,
                       input logic rd_take, input logic fl, input logic cl);
    wr_a = wr; din_a = d; rd_a = rd; flush_a = fl; clr_a = cl; rd_issue_a = rd_take;
    @(posedge clk); #1;
    wr_a = 0; rd_a = 0; flush_a = 0; clr_a = 0; rd_issue_a = 0;
  endtask

  task automatic rd_a_exp(input logic [7:0] e);
    exp_q_a.push_back(e);
    cyc_a(0, 8'h00, 1, 1, 0, 0);
  endtask

  task automatic cyc_b(input logic wr, input logic [7:0] d, input logic rd, input logic rd_take);
    wr_b = wr; din_b = d; rd_b = rd; rd_issue_b = rd_take;
    @(posedge clk); #1;
    wr_b = 0; rd_b = 0; rd_issue_b = 0;
  endtask

  task automatic rd_b_exp(input logic [7:0] e);
    exp_q_b.push_back(e);
    cyc_b(0, 8'h00, 1, 1);
  endtask

  task automatic cyc_c(input logic wr, input logic [7:0] d, input logic rd);
    wr_c = wr; din_c = d; rd_c = rd;
    @(posedge clk); #1;
    wr_c = 0; rd_c = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // An accepted read on one edge shows up on dout by the following negedge.
  always @(posedge clk) begin
    rd_pend_a <= rd_issue_a;
    rd_pend_b <= rd_issue_b;
  end

  always @(negedge clk) begin
    if (rd_pend_a) begin
      if (exp_q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_rd_data: read seen with no expected entry, dout=%0h", dout_a);
      end else begin
        mon_exp = exp_q_a.pop_front();
        check("a_rd_data", dout_a, mon_exp);
      end
    end
    if (rd_pend_b) begin
      if (exp_q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_rd_data: read seen with no expected entry, dout=%0h", dout_b);
      end else begin
        mon_exp = exp_q_b.pop_front();
        check("b_rd_data", dout_b, mon_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w, n;
    rst_n = 1;
    {flush_a, clr_a, wr_a, rd_a} = '0; din_a = '0;
    {flush_b, clr_b, wr_b, rd_b} = '0; din_b = '0;
    {flush_c, clr_c, wr_c, rd_c} = '0; din_c = '0;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_full", full_a, 0);
    check("rst_ae", ae_a, 1);
    check("rst_af", af_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_udf", udf_a, 0);
    check("rst_dout", dout_a, 0);
    check("rst_b_empty", empty_b, 1);
    @(negedge clk);
    rst_n = 1;

    // Basic order: fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cyc_a(1, 8'(i), 0, 0, 0, 0);
      check("fill_count", count_a, i);
      check("fill_af", af_a, (i >= 14));
      check("fill_ae", ae_a, (i <= 2));
      check("fill_full", full_a, (i == 16));
    end

    // Overflow: write 0xAA while full
    cyc_a(1, 8'hAA, 0, 0, 0, 0);
    cyc_a(1, 8'hAA, 0, 0, 0, 0);
    check("ovf_set", ovf_a, 1);
    check("ovf_count", count_a, 16);

    // Drain: the contents must still be 0x01..0x10
    for (int i = 1; i <= 16; i++) rd_a_exp(8'(i));
    check("drain_empty", empty_a, 1);
    check("drain_count", count_a, 0);
    check("drain_udf", udf_a, 0);

    // Underflow: an extra read while empty
    cyc_a(0, 8'h00, 1, 0, 0, 0);
    check("udf_set", udf_a, 1);
    check("udf_dout_hold", dout_a, 8'h10);
    check("udf_count", count_a, 0);

    // clr_err
    cyc_a(0, 8'h00, 0, 0, 0, 1);
    check("clr_ovf", ovf_a, 0);
    check("clr_udf", udf_a, 0);

    // Simultaneous read and write at count 5
    for (int i = 0; i < 5; i++) cyc_a(1, 8'h20 + 8'(i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q_a.push_back(8'h20 + 8'(i));
      cyc_a(1, 8'h25 + 8'(i), 1, 1, 0, 0);
      check("simul_count", count_a, 5);
    end
    for (int i = 0; i < 5; i++) rd_a_exp(8'h24 + 8'(i));
    check("simul_empty", empty_a, 1);

    // Read and write together while empty
    cyc_a(1, 8'h30, 1, 0, 0, 0);
    check("empty_both_count", count_a, 1);
    check("empty_both_udf", udf_a, 1);
    rd_a_exp(8'h30);
    cyc_a(0, 8'h00, 0, 0, 0, 1);

    // Read and write together while full
    for (int i = 0; i < 16; i++) cyc_a(1, 8'h40 + 8'(i), 0, 0, 0, 0);
    exp_q_a.push_back(8'h40);
    cyc_a(1, 8'hEE, 1, 1, 0, 0);
    check("full_both_count", count_a, 15);
    check("full_both_ovf", ovf_a, 1);
    check("full_both_full", full_a, 0);
    check("full_both_af", af_a, 1);
    for (int i = 1; i < 16; i++) rd_a_exp(8'h40 + 8'(i));
    check("full_both_empty", empty_a, 1);
    cyc_a(0, 8'h00, 0, 0, 0, 1);

    // Flush at count 9 with wr_en held
    for (int i = 0; i < 9; i++) cyc_a(1, 8'h50 + 8'(i), 0, 0, 0, 0);
    check("preflush_count", count_a, 9);
    cyc_a(1, 8'h99, 0, 0, 1, 0);
    check("flush_count", count_a, 0);
    check("flush_empty", empty_a, 1);
    check("flush_ae", ae_a, 1);
    cyc_a(1, 8'h77, 0, 0, 0, 0);
    check("postflush_count", count_a, 1);
    rd_a_exp(8'h77);
    check("postflush_empty", empty_a, 1);

    // Odd depth: 20 words in rounds of 3 across the pointer wrap
    w = 0;
    while (w < 20) begin
      n = (20 - w < 3) ? 20 - w : 3;
      for (int j = 0; j < n; j++) cyc_b(1, 8'(w + j), 0, 0);
      check("b_round_count", count_b, n);
      check("b_round_full", full_b, 0);
      for (int j = 0; j < n; j++) rd_b_exp(8'(w + j));
      w += n;
    end
    check("b_rounds_empty", empty_b, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc_b(1, 8'h60 + 8'(k), 0, 0);
      check("b_fill_full", full_b, (k == 5));
      check("b_fill_af", af_b, (k >= 4));
    end
    cyc_b(1, 8'hFF, 0, 0);
    check("b_ovf", ovf_b, 1);
    for (int k = 1; k <= 5; k++) rd_b_exp(8'h60 + 8'(k));
    check("b_drain_empty", empty_b, 1);

    // FWFT
    cyc_c(1, 8'h3C, 0);
    check("fwft_dout_first", dout_c, 8'h3C);
    check("fwft_count1", count_c, 1);
    cyc_c(1, 8'h3D, 0);
    check("fwft_head_hold", dout_c, 8'h3C);
    check("fwft_count2", count_c, 2);
    cyc_c(0, 8'h00, 1);
    check("fwft_dout_pop", dout_c, 8'h3D);
    check("fwft_count_pop", count_c, 1);
    cyc_c(0, 8'h00, 1);
    check("fwft_empty", empty_c, 1);

    // Asynchronous reset in the middle of a cycle
    cyc_a(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc_a(1, 8'h80 + 8'(i), 0, 0, 0, 0);
    check("prereset_count", count_a, 7);
    check("prereset_udf", udf_a, 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_count", count_a, 0);
    check("arst_empty", empty_a, 1);
    check("arst_full", full_a, 0);
    check("arst_ae", ae_a, 1);
    check("arst_af", af_a, 0);
    check("arst_udf", udf_a, 0);
    check("arst_dout", dout_a, 0);
    #10 rst_n = 1;

    repeat (2) @(posedge clk);
    #1;
    check("a_exp_q_drained", exp_q_a.size(), 0);
    check("b_exp_q_drained", exp_q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
